serial_adder: RTL and testbench

//   Parametrised multi-cycle adder/subtractor built around a DIGIT-bit

---
 rtl/serial_adder.sv | 98 +++++++++
 tb/tb_serial_adder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through one slice plus a carry register.
// Latency: start accepted at edge 0, busy for edges 1..N, done pulses after edge N (N = WIDTH/DIGIT).
// Backpressure: none; start is accepted only in IDLE or DONE and ignored while busy.
module serial_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]       opa, opb;
    logic                   carry;
    logic [CW-1:0]          cnt;
    logic                   accept;
    logic                   last;
    logic [DIGIT:0]         slice;
    logic                   msb_cin;
    logic [WIDTH+DIGIT-1:0] sum_cat;

    assign accept  = start && ((state_q == IDLE) || (state_q == DONE));
    assign last    = (cnt == CW'(N - 1));
    assign slice   = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    // Carry into the slice's top bit recovered from its sum bit; on the last digit this is the MSB carry-in.
    assign msb_cin = slice[DIGIT-1] ^ opa[DIGIT-1] ^ opb[DIGIT-1];
    assign sum_cat = {slice[DIGIT-1:0], sum};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == RUN);
            done    <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa       <= '0;
            opb       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : carry_in;
            cnt   <= '0;
        end else if (state_q == RUN) begin
            opa   <= opa >> DIGIT;
            opb   <= opb >> DIGIT;
            carry <= slice[DIGIT];
            cnt   <= cnt + CW'(1);
            sum   <= sum_cat[WIDTH+DIGIT-1:DIGIT];
            if (last) begin
                carry_out <= slice[DIGIT];
                overflow  <= msb_cin ^ slice[DIGIT];
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: several width/digit instances, scoreboard of a +/- b results.
// Expected results are queued when start is driven and compared on each done pulse.
module tb_serial_adder;

    logic        core_clk;
    logic        rst_n;
    logic        sub;
    logic        carry_in;
    logic [31:0] a, b;
    logic [6:0]  st;
    logic [6:0]  busyv, donev, cov, ovv;
    logic [31:0] sumv [7];

    logic [0:0]  s_w1;
    logic [7:0]  s_w8d1, s_w8d4;
    logic [31:0] s_d1, s_d2, s_d8, s_d32;

    int n_tests = 0;
    int n_fail  = 0;
    logic [33:0] sb [$];

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    serial_adder #(.WIDTH(1), .DIGIT(1)) u_w1 (
        .clk(core_clk), .rst_n(rst_n), .start(st[0]), .sub(sub), .a(a[0:0]), .b(b[0:0]),
        .carry_in(carry_in), .busy(busyv[0]), .done(donev[0]), .sum(s_w1),
        .carry_out(cov[0]), .overflow(ovv[0]));
    serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(core_clk), .rst_n(rst_n), .start(st[1]), .sub(sub), .a(a[7:0]), .b(b[7:0]),
        .carry_in(carry_in), .busy(busyv[1]), .done(donev[1]), .sum(s_w8d1),
        .carry_out(cov[1]), .overflow(ovv[1]));
    serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(core_clk), .rst_n(rst_n), .start(st[2]), .sub(sub), .a(a[7:0]), .b(b[7:0]),
        .carry_in(carry_in), .busy(busyv[2]), .done(donev[2]), .sum(s_w8d4),
        .carry_out(cov[2]), .overflow(ovv[2]));
    serial_adder #(.WIDTH(32), .DIGIT(1)) u_d1 (
        .clk(core_clk), .rst_n(rst_n), .start(st[3]), .sub(sub), .a(a), .b(b),
        .carry_in(carry_in), .busy(busyv[3]), .done(donev[3]), .sum(s_d1),
        .carry_out(cov[3]), .overflow(ovv[3]));
    serial_adder #(.WIDTH(32), .DIGIT(2)) u_d2 (
        .clk(core_clk), .rst_n(rst_n), .start(st[4]), .sub(sub), .a(a), .b(b),
        .carry_in(carry_in), .busy(busyv[4]), .done(donev[4]), .sum(s_d2),
        .carry_out(cov[4]), .overflow(ovv[4]));
    serial_adder #(.WIDTH(32), .DIGIT(8)) u_d8 (
        .clk(core_clk), .rst_n(rst_n), .start(st[5]), .sub(sub), .a(a), .b(b),
        .carry_in(carry_in), .busy(busyv[5]), .done(donev[5]), .sum(s_d8),
        .carry_out(cov[5]), .overflow(ovv[5]));
    serial_adder #(.WIDTH(32), .DIGIT(32)) u_d32 (
        .clk(core_clk), .rst_n(rst_n), .start(st[6]), .sub(sub), .a(a), .b(b),
        .carry_in(carry_in), .busy(busyv[6]), .done(donev[6]), .sum(s_d32),
        .carry_out(cov[6]), .overflow(ovv[6]));

    assign sumv[0] = {31'b0, s_w1};
    assign sumv[1] = {24'b0, s_w8d1};
    assign sumv[2] = {24'b0, s_w8d4};
    assign sumv[3] = s_d1;
    assign sumv[4] = s_d2;
    assign sumv[5] = s_d8;
    assign sumv[6] = s_d32;

    function automatic int wid(int k);
        case (k)
            0:       return 1;
            1, 2:    return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int nn(int k);
        case (k)
            0:       return 1;
            1:       return 8;
            2:       return 2;
            3:       return 32;
            4:       return 16;
            5:       return 4;
            default: return 1;
        endcase
    endfunction

    // Reference: {overflow, carry_out, sum}; overflow from operand/result sign rule.
    function automatic logic [33:0] model(int w, logic s, logic [31:0] x, logic [31:0] y, logic ci);
        logic [32:0] m, xa, ya, r;
        logic        c0, co, ov;
        m  = (33'd1 << w) - 33'd1;
        xa = {1'b0, x} & m;
        ya = (s ? ~{1'b0, y} : {1'b0, y}) & m;
        c0 = s ? 1'b1 : ci;
        r  = xa + ya + {32'b0, c0};
        co = r[w];
        ov = (xa[w-1] == ya[w-1]) && (r[w-1] != xa[w-1]);
        r  = r & m;
        return {ov, co, r[31:0]};
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(int k, logic s, logic [31:0] x, logic [31:0] y, logic ci, bit poke, string tag);
        int          cyc;
        logic [33:0] e, got;
        @(negedge core_clk);
        a = x; b = y; sub = s; carry_in = ci; st[k] = 1'b1;
        sb.push_back(model(wid(k), s, x, y, ci));
        @(negedge core_clk);
        st[k] = 1'b0;
        chk({tag, ":busy"}, 64'(busyv[k]), 64'd1);
        if (poke) begin
            a = $urandom; b = $urandom; sub = ~s; carry_in = ~ci; st[k] = 1'b1;
        end
        cyc = 0;
        while (!donev[k] && cyc < 300) begin
            @(negedge core_clk);
            st[k] = 1'b0;
            cyc++;
        end
        chk({tag, ":lat"}, 64'(cyc), 64'(nn(k)));
        got = {ovv[k], cov[k], sumv[k]};
        e   = sb.pop_front();
        chk({tag, ":res"}, 64'(got), 64'(e));
        @(negedge core_clk);
        chk({tag, ":pulse"}, 64'(donev[k]), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  bta [3];
        logic [7:0]  btb [3];
        logic [33:0] e, got;
        logic        seen;

        rst_n = 1'b0; st = '0; sub = 1'b0; carry_in = 1'b0; a = '0; b = '0;
        #12;
        chk("rst:busy", 64'(busyv), 64'd0);
        chk("rst:done", 64'(donev), 64'd0);
        chk("rst:sum3", 64'(sumv[3]), 64'd0);
        chk("rst:co_ov", 64'({cov, ovv}), 64'd0);
        @(negedge core_clk);
        rst_n = 1'b1;

        // Full-adder truth table on the 1-bit instance
        for (int i = 0; i < 8; i++)
            run_op(0, 1'b0, {31'b0, i[2]}, {31'b0, i[1]}, i[0], 1'b0, $sformatf("fa%0d", i));

        run_op(1, 1'b0, 32'hFF, 32'h01, 1'b0, 1'b0, "w8_ff_01");
        run_op(1, 1'b0, 32'h7F, 32'h01, 1'b0, 1'b0, "w8_ovf");
        run_op(1, 1'b1, 32'h05, 32'h07, 1'b0, 1'b0, "w8_sub");
        run_op(1, 1'b1, 32'h80, 32'h01, 1'b1, 1'b1, "w8_subovf");
        run_op(2, 1'b0, 32'h3C, 32'hC4, 1'b0, 1'b0, "w8d4");
        run_op(2, 1'b0, 32'h12, 32'h34, 1'b1, 1'b1, "w8d4_poke");

        // start held high: three back-to-back operations, done every third cycle
        bta = '{8'h3C, 8'h7F, 8'h80};
        btb = '{8'hC4, 8'h01, 8'hFF};
        @(negedge core_clk);
        a = {24'b0, bta[0]}; b = {24'b0, btb[0]}; sub = 1'b0; carry_in = 1'b0; st[2] = 1'b1;
        sb.push_back(model(8, 1'b0, {24'b0, bta[0]}, {24'b0, btb[0]}, 1'b0));
        for (int i = 0; i < 3; i++) begin
            @(negedge core_clk);
            if (i < 2) begin
                a = {24'b0, bta[i+1]}; b = {24'b0, btb[i+1]};
                sb.push_back(model(8, 1'b0, {24'b0, bta[i+1]}, {24'b0, btb[i+1]}, 1'b0));
            end else begin
                st[2] = 1'b0;
            end
            chk($sformatf("b2b%0d:busy", i), 64'(busyv[2]), 64'd1);
            @(negedge core_clk);
            chk($sformatf("b2b%0d:early", i), 64'(donev[2]), 64'd0);
            @(negedge core_clk);
            chk($sformatf("b2b%0d:done", i), 64'(donev[2]), 64'd1);
            got = {ovv[2], cov[2], sumv[2]};
            e   = sb.pop_front();
            chk($sformatf("b2b%0d:res", i), 64'(got), 64'(e));
        end
        @(negedge core_clk);
        chk("b2b:idle", 64'({busyv[2], donev[2]}), 64'd0);

        // Reset in the third RUN cycle aborts the operation
        @(negedge core_clk);
        a = 32'h55; b = 32'h0F; sub = 1'b0; carry_in = 1'b0; st[1] = 1'b1;
        @(negedge core_clk);
        st[1] = 1'b0;
        repeat (2) @(negedge core_clk);
        rst_n = 1'b0;
        #1;
        chk("abort:busy", 64'(busyv[1]), 64'd0);
        chk("abort:done", 64'(donev[1]), 64'd0);
        chk("abort:sum", 64'(sumv[1]), 64'd0);
        chk("abort:co_ov", 64'({cov[1], ovv[1]}), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge core_clk);
            if (i == 1) rst_n = 1'b1;
            seen = seen | donev[1];
        end
        chk("abort:nodone", 64'(seen), 64'd0);
        chk("abort:idle", 64'(busyv[1]), 64'd0);

        run_op(3, 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, "w32_ovf");
        run_op(5, 1'b1, 32'h8000_0000, 32'h1, 1'b0, 1'b0, "w32_subovf");
        run_op(6, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, "w32_wrap");

        for (int k = 3; k < 7; k++)
            for (int i = 0; i < 250; i++)
                run_op(k, 1'(($urandom % 2)), $urandom, $urandom, 1'(($urandom % 2)),
                       (i % 8) == 0, $sformatf("rnd%0d_%0d", k, i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
